// File: rtl/and_chk_pkg.sv
// rtl/and_chk_pkg.sv - shared types and defaults for the AND3 response checker
package and_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } chk_state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_LAT   = 1;
  localparam int DEF_CNT_W = 16;
  localparam int LAT_MAX   = 7;
  localparam int DRAIN_W   = 3;

endpackage

// File: rtl/chk_delay_line.sv
// rtl/chk_delay_line.sv - valid-tagged shift register matching the DUT latency
module chk_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, clr};
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [DEPTH-1:0] vld_q, vld_d;
      logic [WIDTH-1:0] data_q [DEPTH];
      logic [WIDTH-1:0] data_d [DEPTH];

      always_comb begin
        vld_d     = vld_q;
        data_d    = data_q;
        vld_d[0]  = in_valid;
        data_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld_d[i]  = vld_q[i-1];
          data_d[i] = data_q[i-1];
        end
        if (clr) begin
          vld_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
          vld_q  <= vld_d;
          data_q <= data_d;
        end
      end

      assign out_valid = vld_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/and3_resp_checker.sv
// rtl/and3_resp_checker.sv - compares delayed DUT output to &stim and tallies a verdict
module and3_resp_checker
  import and_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LAT   = DEF_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim,
  input  logic             stim_last,
  input  logic             dut_out,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             result_valid,
  output logic             result_ok
);

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((LAT > 0) ? LAT - 1 : 0);

  chk_state_e         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d;
  logic               ff_vld_q, ff_vld_d;
  logic [WIDTH-1:0]   ff_vec_q, ff_vec_d;

  logic             dl_clr, dl_push, dl_vld, cmp_en, match;
  logic [WIDTH-1:0] dl_vec;

  assign dl_clr  = (state_q == ST_IDLE) && start;
  assign dl_push = (state_q == ST_RUN) && stim_valid;
  assign cmp_en  = dl_vld && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign match   = ((&dl_vec) == dut_out);

  chk_delay_line #(
    .DEPTH (LAT),
    .WIDTH (WIDTH)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (dl_clr),
    .in_valid  (dl_push),
    .in_data   (stim),
    .out_valid (dl_vld),
    .out_data  (dl_vec)
  );

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ff_vld_d = ff_vld_q;
    ff_vec_d = ff_vec_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          pass_d   = '0;
          fail_d   = '0;
          ff_vld_d = 1'b0;
          ff_vec_d = '0;
        end
      end
      ST_RUN: begin
        if (stim_valid && stim_last) begin
          state_d = (LAT == 0) ? ST_REPORT : ST_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        // drain_q counts the remaining compare cycles after this one
        if (drain_q == '0) state_d = ST_REPORT;
        else               drain_d = drain_q - 1'b1;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (cmp_en) begin
      if (match) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + CNT_W'(1);
        if (!ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_vec_d = dl_vec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      drain_q  <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ff_vld_q <= ff_vld_d;
      ff_vec_q <= ff_vec_d;
    end
  end

  assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_vec = ff_vec_q;
  assign result_valid   = (state_q == ST_REPORT);
  assign result_ok      = result_valid && (fail_q == '0) && (pass_q != '0);

endmodule

// File: tb/tb_and3_resp_checker.sv
// tb/tb_and3_resp_checker.sv - scoreboard bench over four checker configurations
module tb_and3_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n, stim_valid, stim_last;
  logic [2:0] stim;
  logic [3:0] start_v, dut_out_v;
  logic [3:0] busy_v, rv_v, ok_v, ffv_v;
  logic [15:0] pass0, pass1, pass2, fail0, fail1, fail2;
  logic [1:0]  pass3, fail3;
  logic [2:0]  vec0, vec1, vec2, vec3;
  int fault;
  int sel;
  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // fixture DUT: AND3 with per-instance latency and an injectable fault
  function automatic logic fix(input logic [2:0] v, input int f);
    case (f)
      1:       return 1'b1;
      2:       return ~(&v);
      default: return &v;
    endcase
  endfunction

  logic [2:0] hist [8];
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= stim;
  end

  assign dut_out_v[0] = fix(hist[0], fault);
  assign dut_out_v[1] = fix(hist[2], fault);
  assign dut_out_v[2] = fix(stim, fault);
  assign dut_out_v[3] = fix(hist[0], fault);

  and3_resp_checker #(.WIDTH(3), .LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stim_valid(stim_valid), .stim(stim),
    .stim_last(stim_last), .dut_out(dut_out_v[0]), .busy(busy_v[0]), .pass_cnt(pass0),
    .fail_cnt(fail0), .first_fail_vld(ffv_v[0]), .first_fail_vec(vec0),
    .result_valid(rv_v[0]), .result_ok(ok_v[0]));
  and3_resp_checker #(.WIDTH(3), .LAT(3), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stim_valid(stim_valid), .stim(stim),
    .stim_last(stim_last), .dut_out(dut_out_v[1]), .busy(busy_v[1]), .pass_cnt(pass1),
    .fail_cnt(fail1), .first_fail_vld(ffv_v[1]), .first_fail_vec(vec1),
    .result_valid(rv_v[1]), .result_ok(ok_v[1]));
  and3_resp_checker #(.WIDTH(3), .LAT(0), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stim_valid(stim_valid), .stim(stim),
    .stim_last(stim_last), .dut_out(dut_out_v[2]), .busy(busy_v[2]), .pass_cnt(pass2),
    .fail_cnt(fail2), .first_fail_vld(ffv_v[2]), .first_fail_vec(vec2),
    .result_valid(rv_v[2]), .result_ok(ok_v[2]));
  and3_resp_checker #(.WIDTH(3), .LAT(1), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .stim_valid(stim_valid), .stim(stim),
    .stim_last(stim_last), .dut_out(dut_out_v[3]), .busy(busy_v[3]), .pass_cnt(pass3),
    .fail_cnt(fail3), .first_fail_vld(ffv_v[3]), .first_fail_vec(vec3),
    .result_valid(rv_v[3]), .result_ok(ok_v[3]));

  logic [31:0] m_pass, m_fail;
  logic [2:0]  m_vec;
  always_comb begin
    m_pass = {16'd0, pass0};
    m_fail = {16'd0, fail0};
    m_vec  = vec0;
    case (sel)
      1: begin m_pass = {16'd0, pass1}; m_fail = {16'd0, fail1}; m_vec = vec1; end
      2: begin m_pass = {16'd0, pass2}; m_fail = {16'd0, fail2}; m_vec = vec2; end
      3: begin m_pass = {30'd0, pass3}; m_fail = {30'd0, fail3}; m_vec = vec3; end
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0] vec;
    logic       match;
  } sb_t;
  sb_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input int s, input string tag);
    sel = s;
    #0;
    chk({tag, "_busy"}, {31'd0, busy_v[s]}, 32'd0);
    chk({tag, "_pass"}, m_pass, 32'd0);
    chk({tag, "_fail"}, m_fail, 32'd0);
    chk({tag, "_ffv"}, {31'd0, ffv_v[s]}, 32'd0);
    chk({tag, "_vec"}, {29'd0, m_vec}, 32'd0);
    chk({tag, "_rv"}, {31'd0, rv_v[s]}, 32'd0);
    chk({tag, "_ok"}, {31'd0, ok_v[s]}, 32'd0);
  endtask

  task automatic do_start(input int s);
    sel = s;
    start_v = 4'b0001 << s;
    step();
    start_v = '0;
    chk("busy_after_start", {31'd0, busy_v[s]}, 32'd1);
  endtask

  task automatic send(input logic [2:0] v, input logic last);
    stim = v;
    stim_valid = 1'b1;
    stim_last = last;
    sb.push_back('{vec: v, match: (fix(v, fault) === (&v))});
    step();
    stim_valid = 1'b0;
    stim_last = 1'b0;
  endtask

  // called right after the stim_last cycle; pops the whole run from the scoreboard
  task automatic check_run(input string tag, input int lat, input int maxc);
    int n, np, nf;
    logic ffv;
    logic [2:0] fvec;
    sb_t e;
    n = 1;
    while (rv_v[sel] !== 1'b1 && n <= 20) begin
      step();
      n++;
    end
    np = 0; nf = 0; ffv = 1'b0; fvec = 3'd0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.match) np++;
      else begin
        nf++;
        if (!ffv) begin ffv = 1'b1; fvec = e.vec; end
      end
    end
    chk({tag, "_latency"}, n, lat + 1);
    chk({tag, "_pass"}, m_pass, (np > maxc) ? maxc : np);
    chk({tag, "_fail"}, m_fail, (nf > maxc) ? maxc : nf);
    chk({tag, "_ffv"}, {31'd0, ffv_v[sel]}, {31'd0, ffv});
    chk({tag, "_ffvec"}, {29'd0, m_vec}, {29'd0, fvec});
    chk({tag, "_ok"}, {31'd0, ok_v[sel]}, {31'd0, (nf == 0) && (np != 0)});
    step();
    chk({tag, "_rv_pulse"}, {31'd0, rv_v[sel]}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy_v[sel]}, 32'd0);
  endtask

  logic [2:0] perm [8];

  initial begin
    rst_n = 1'b0; start_v = '0; stim_valid = 1'b0; stim_last = 1'b0; stim = '0;
    fault = 0; sel = 0;
    repeat (3) step();
    for (int s = 0; s < 4; s++) chk_idle_outputs(s, "reset");
    rst_n = 1'b1;
    step();

    // LAT=1, good DUT, back-to-back
    fault = 0;
    do_start(0);
    send(3'b000, 1'b0);
    send(3'b001, 1'b0);
    send(3'b111, 1'b1);
    check_run("lat1_good", 1, 65535);

    // LAT=1, DUT stuck-at-1
    fault = 1;
    do_start(0);
    send(3'b000, 1'b0);
    send(3'b001, 1'b0);
    send(3'b111, 1'b1);
    check_run("lat1_stuck1", 1, 65535);

    // LAT=3, gaps between vectors
    fault = 0;
    do_start(1);
    for (int i = 0; i < 8; i++) begin
      send(3'(i), i == 7);
      if (i < 7) repeat (i % 3) step();
    end
    check_run("lat3_gaps", 3, 65535);

    // LAT=0, inverted DUT, stray start mid-run
    fault = 2;
    perm[0] = 3'd5; perm[1] = 3'd0; perm[2] = 3'd7; perm[3] = 3'd3;
    perm[4] = 3'd1; perm[5] = 3'd6; perm[6] = 3'd2; perm[7] = 3'd4;
    do_start(2);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        start_v = 4'b0100;
        step();
        start_v = '0;
        chk("lat0_start_ignored_busy", {31'd0, busy_v[2]}, 32'd1);
        chk("lat0_start_ignored_fail", m_fail, 32'd4);
      end
      send(perm[i], i == 7);
    end
    check_run("lat0_inv", 0, 65535);

    // CNT_W=2 saturation
    fault = 0;
    do_start(3);
    for (int i = 0; i < 5; i++) send(3'(i + 3), i == 4);
    check_run("cntw2_sat", 1, 3);

    // reset mid-run, then a clean run
    do_start(0);
    send(3'b111, 1'b0);
    send(3'b010, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs(0, "midrst");
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    chk_idle_outputs(0, "post_rst");
    do_start(0);
    send(3'b111, 1'b0);
    send(3'b110, 1'b0);
    send(3'b011, 1'b1);
    check_run("after_rst", 1, 65535);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
